// File: rtl/mips_memory_arbiter.sv
// Arbiter that shares one single-ported, fixed-latency memory between instruction fetch and
// data access. Data requests have priority, but a fairness streak counter guarantees fetch progress.
module mips_memory_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_LATENCY    = 2,
  parameter int MAX_DATA_BURST = 4
) (
  input  logic                  ClockPulse,
  input  logic                  ResetN,
  input  logic                  IfReq,
  input  logic [ADDR_WIDTH-1:0] IfAddr,
  output logic                  IfReady,
  output logic                  IfValid,
  output logic [DATA_WIDTH-1:0] IfData,
  input  logic                  MemReq,
  input  logic                  MemWrite,
  input  logic [ADDR_WIDTH-1:0] MemAddr,
  input  logic [DATA_WIDTH-1:0] MemWData,
  output logic                  MemReady,
  output logic                  MemValid,
  output logic [DATA_WIDTH-1:0] MemRData,
  output logic                  RamEn,
  output logic                  RamWe,
  output logic [ADDR_WIDTH-1:0] RamAddr,
  output logic [DATA_WIDTH-1:0] RamWData,
  input  logic [DATA_WIDTH-1:0] RamRData,
  output logic                  PipelineStall
);

  // state | meaning
  // IDLE  | no transaction; arbitrate and grant one requester
  // ISSUE | RamEn strobe cycle; wait counter loaded
  // WAIT  | counting down memory latency; capture read data on last cycle
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam logic [3:0] LATENCY = 4'(MEM_LATENCY);
  localparam logic [3:0] MAX_B   = 4'(MAX_DATA_BURST);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] streak;
  logic [3:0] wait_cnt;
  logic       owner_fetch;
  logic       grant_if;
  logic       grant_mem;
  logic       capture;

  always_comb begin
    state_nxt = state;
    grant_mem = 1'b0;
    grant_if  = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        grant_mem = MemReq && (!IfReq || (streak < MAX_B));
        grant_if  = IfReq && !grant_mem;
        if (grant_mem || grant_if) state_nxt = ISSUE;
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        capture = (wait_cnt == 4'd1);
        if (capture) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign IfReady       = grant_if;
  assign MemReady      = grant_mem;
  assign RamEn         = (state == ISSUE);
  assign PipelineStall = (state != IDLE) || (IfReq && MemReq);

  always_ff @(posedge ClockPulse or negedge ResetN) begin
    if (!ResetN) begin
      state       <= IDLE;
      streak      <= 4'd0;
      wait_cnt    <= 4'd0;
      owner_fetch <= 1'b0;
      RamWe       <= 1'b0;
      RamAddr     <= '0;
      RamWData    <= '0;
      IfData      <= '0;
      MemRData    <= '0;
      IfValid     <= 1'b0;
      MemValid    <= 1'b0;
    end else begin
      state    <= state_nxt;
      IfValid  <= 1'b0;
      MemValid <= 1'b0;

      if (grant_mem) begin
        RamAddr     <= MemAddr;
        RamWData    <= MemWData;
        RamWe       <= MemWrite;
        owner_fetch <= 1'b0;
        if (IfReq && (streak < MAX_B)) streak <= streak + 4'd1;
      end else if (grant_if) begin
        RamAddr     <= IfAddr;
        RamWe       <= 1'b0;
        owner_fetch <= 1'b1;
        streak      <= 4'd0;
      end

      if (state == ISSUE) begin
        wait_cnt <= LATENCY;
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt - 4'd1;
      end

      // RamWe still reflects the outstanding transaction: stores leave MemRData untouched
      if (capture) begin
        if (owner_fetch) begin
          IfData  <= RamRData;
          IfValid <= 1'b1;
        end else begin
          if (!RamWe) MemRData <= RamRData;
          MemValid <= 1'b1;
        end
      end
    end
  end

endmodule
